// File: rtl/param_value_checker.sv
// param_value_checker: locks after LOCK_COUNT consecutive beats equal to (INVERT ? ~EXPECT : EXPECT), faults on a mismatch while locked.
// Optional macro PARAM_CHECK_LAST_BAD_EN adds port last_bad holding the data of the latest mismatching beat.
module param_value_checker #(
   parameter logic [1:0] EXPECT     = 2'b00,
   parameter bit         INVERT     = 1'b0,
   parameter int         LOCK_COUNT = 4,
   parameter int         CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [1:0]       in_data,
   output logic             in_ready,
   output logic             locked,
   output logic             err,
`ifdef PARAM_CHECK_LAST_BAD_EN
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [1:0]       last_bad
`else
   output logic [CNT_W-1:0] mismatch_cnt
`endif
);
   localparam logic [1:0] EFF = INVERT ? ~EXPECT : EXPECT;
   localparam logic [3:0] LC  = 4'(LOCK_COUNT);
   typedef enum logic [1:0] {SEARCH, LOCKED, FAULT} state_t;
   state_t     state, state_n;
   logic [3:0] run, run_n;
   logic       accept, match, bad;
   assign in_ready = state != FAULT && !clear;
   assign accept   = in_valid && in_ready;
   assign match    = in_data == EFF;
   assign bad      = accept && !match;
   always_comb begin
      state_n = state;
      run_n   = run;
      if (accept && state == SEARCH) begin
         run_n   = match ? run + 4'd1 : 4'd0;
         state_n = (match && run + 4'd1 == LC) ? LOCKED : SEARCH;
      end else if (bad && state == LOCKED) begin
         state_n = FAULT;
      end
      if (clear) begin
         state_n = SEARCH;
         run_n   = 4'd0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SEARCH;
         run          <= 4'd0;
         locked       <= 1'b0;
         err          <= 1'b0;
         mismatch_cnt <= '0;
      end else begin
         state        <= state_n;
         run          <= run_n;
         locked       <= state_n == LOCKED;
         err          <= clear ? 1'b0 : err || (bad && state == LOCKED);
         mismatch_cnt <= clear ? '0 : (bad && mismatch_cnt != '1) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;
      end
   end
`ifdef PARAM_CHECK_LAST_BAD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_bad <= 2'b00;
      else if (clear)
         last_bad <= 2'b00;
      else if (bad)
         last_bad <= in_data;
   end
`endif
endmodule

// File: tb/tb_param_value_checker.sv
// tb_param_value_checker: directed checks of three checker configurations sharing one clock and reset.
module tb_param_value_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_clear = 0, a_valid = 0, b_clear = 0, b_valid = 0, c_clear = 0, c_valid = 0;
   logic [1:0] a_data = 0, b_data = 0, c_data = 0;
   logic a_ready, a_locked, a_err, b_ready, b_locked, b_err, c_ready, c_locked, c_err;
   logic [7:0] a_cnt, b_cnt;
   logic [1:0] c_cnt;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;

   param_value_checker #(.EXPECT(2'b01), .INVERT(1'b0), .LOCK_COUNT(4), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_ready), .locked(a_locked), .err(a_err), .mismatch_cnt(a_cnt));
   param_value_checker #(.EXPECT(2'b01), .INVERT(1'b1), .LOCK_COUNT(4), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_ready), .locked(b_locked), .err(b_err), .mismatch_cnt(b_cnt));
`ifdef PARAM_CHECK_LAST_BAD_EN
   logic [1:0] c_last;
   param_value_checker #(.EXPECT(2'b00), .INVERT(1'b0), .LOCK_COUNT(1), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .clear(c_clear), .in_valid(c_valid), .in_data(c_data),
      .in_ready(c_ready), .locked(c_locked), .err(c_err), .mismatch_cnt(c_cnt), .last_bad(c_last));
`else
   param_value_checker #(.EXPECT(2'b00), .INVERT(1'b0), .LOCK_COUNT(1), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .clear(c_clear), .in_valid(c_valid), .in_data(c_data),
      .in_ready(c_ready), .locked(c_locked), .err(c_err), .mismatch_cnt(c_cnt));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held: state SEARCH, beats ignored, in_ready follows ~clear
      step();
      a_valid = 1; a_data = 2'b01;
      repeat (5) step();
      chk("rst_locked", a_locked, 0);
      chk("rst_err", a_err, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_ready", a_ready, 1);
      a_clear = 1; #1;
      chk("rst_ready_clear", a_ready, 0);
      a_clear = 0; a_valid = 0;
      rst = 0;
      step();
      // four matching beats lock on the fourth
      a_valid = 1; a_data = 2'b01;
      repeat (3) step();
      chk("a_lock_after3", a_locked, 0);
      step();
      chk("a_lock_after4", a_locked, 1);
      chk("a_err_lock", a_err, 0);
      chk("a_cnt_lock", a_cnt, 0);
      a_valid = 0;
      // a mismatch in SEARCH restarts the run
      a_clear = 1; step();
      chk("a_clear_unlock", a_locked, 0);
      a_clear = 0; a_valid = 1;
      for (int i = 0; i < 7; i++) begin
         a_data = (i == 3) ? 2'b11 : 2'b01;
         step();
      end
      chk("a_restart_after7", a_locked, 0);
      step();
      chk("a_restart_after8", a_locked, 1);
      chk("a_restart_cnt", a_cnt, 1);
      chk("a_restart_err", a_err, 0);
      a_valid = 0;
      // inverted expectation, then a fault while locked
      b_valid = 1; b_data = 2'b10;
      repeat (4) step();
      chk("b_locked", b_locked, 1);
      b_data = 2'b01;
      step();
      chk("b_fault_err", b_err, 1);
      chk("b_fault_locked", b_locked, 0);
      chk("b_fault_cnt", b_cnt, 1);
      chk("b_fault_ready", b_ready, 0);
      b_data = 2'b10;
      step();
      chk("b_fault_hold_err", b_err, 1);
      chk("b_fault_hold_cnt", b_cnt, 1);
      // clear has priority over the offered beat
      b_clear = 1; #1;
      chk("b_clear_ready", b_ready, 0);
      step();
      b_clear = 0; #1;
      chk("b_cleared_err", b_err, 0);
      chk("b_cleared_cnt", b_cnt, 0);
      chk("b_cleared_locked", b_locked, 0);
      chk("b_cleared_ready", b_ready, 1);
      b_valid = 0;
      // saturation at CNT_W=2
      c_valid = 1; c_data = 2'b11;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("c_sat", c_cnt, (i < 3) ? i + 1 : 3);
      end
      chk("c_sat_locked", c_locked, 0);
`ifdef PARAM_CHECK_LAST_BAD_EN
      chk("c_last_11", c_last, 2'b11);
      c_data = 2'b10;
      step();
      chk("c_last_10", c_last, 2'b10);
`endif
      // LOCK_COUNT=1 locks on the first match, then faults
      c_data = 2'b00;
      step();
      chk("c_lock1", c_locked, 1);
      c_data = 2'b10;
      step();
      chk("c_fault_err", c_err, 1);
      chk("c_fault_cnt", c_cnt, 3);
      c_valid = 0;
      // mid-run reset abandons progress asynchronously
      rst = 1; #1;
      chk("mid_rst_a_locked", a_locked, 0);
      chk("mid_rst_c_err", c_err, 0);
      chk("mid_rst_c_cnt", c_cnt, 0);
`ifdef PARAM_CHECK_LAST_BAD_EN
      chk("mid_rst_last_bad", c_last, 2'b00);
`endif
      step();
      rst = 0;
      a_valid = 1; a_data = 2'b01;
      repeat (3) step();
      chk("post_rst_after3", a_locked, 0);
      step();
      chk("post_rst_after4", a_locked, 1);
      a_valid = 0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
